fxp_bit_serializer: RTL
=======================

FXP_BIT_SERIALIZER -- requirements
Module: fxp_bit_serializer

Interface
REQ-001 SHALL have parameter FXP_WIDTH, default 4: bit width of the fixed-point operand; legal range 2..16.
REQ-002 SHALL have parameter FP_WIDTH, default 32: floating-point operand width.
REQ-003 SHALL have parameter FP_FRAC_WIDTH, default 23: fraction width; exponent width EXP_W = FP_WIDTH-FP_FRAC_WIDTH-1.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid  input  1: input operand pair valid.
REQ-007 SHALL have port in_ready  output  1: block can accept a new operand pair.
REQ-008 SHALL have port in_fxp  input  FXP_WIDTH: fixed-point operand.
REQ-009 SHALL have port in_signed  input  1: 1 = in_fxp is two's complement; 0 = unsigned.
REQ-010 SHALL have port in_b  input  FP_WIDTH: floating-point operand {sign, exp, frac}.
REQ-011 SHALL have port out_valid  output  1: output beat valid.
REQ-012 SHALL have port out_ready  input  1: downstream multiplier stage accepts the beat.
REQ-013 SHALL have ports a_bit (1), a_sign (1), a_exp (4) outputs: current bit, its weight sign, its bit position.
REQ-014 SHALL have port b  output  FP_WIDTH: registered copy of in_b.
REQ-015 SHALL have port b_zero  output  1: registered flag, 1 when exponent field of in_b is zero.
REQ-016 SHALL have port out_last  output  1: marks the final beat of an operand.

Function
REQ-017 SHALL implement two states: IDLE (no operand held) and BUSY (emitting beats).
REQ-018 SHALL drive in_ready = 1 in IDLE, and in BUSY only when out_last && out_ready (back-to-back accept); otherwise 0.
REQ-019 SHALL accept an operand on in_valid && in_ready, registering in_fxp, in_signed, in_b, b_zero and setting index idx = 0; state becomes BUSY.
REQ-020 SHALL in BUSY assert out_valid, with a_bit = fxp[idx], a_exp = idx (zero-extended to 4 bits), a_sign = in_signed && (idx == FXP_WIDTH-1), out_last = (idx == FXP_WIDTH-1).
REQ-021 SHALL emit exactly FXP_WIDTH beats per operand, idx ascending LSB to MSB, including beats with a_bit = 0 (no zero skipping).
REQ-022 SHALL advance idx only on out_valid && out_ready; while out_ready = 0 all outputs SHALL hold stable.
REQ-023 SHALL on the last beat handshake return to IDLE unless a new operand is accepted in the same cycle, in which case it SHALL stay BUSY with idx = 0 and new operand loaded (no bubble).
REQ-024 SHALL compute b_zero = (in_b exponent field == 0), independent of sign and fraction (denormals flushed to zero).
REQ-025 SHALL present first beat on the cycle after acceptance (latency 1 cycle).
REQ-026 SHALL ignore in_valid when in_ready = 0; in_fxp/in_b changes then have no effect.

Reset
REQ-027 SHALL on reset = 0 immediately (asynchronously) force state IDLE, idx = 0, out_valid = 0, out_last = 0, a_bit = 0, a_sign = 0, a_exp = 0, b = 0, b_zero = 0.
REQ-028 SHALL drive in_ready = 1 from the first clock edge after reset deasserts; a reset mid-operand SHALL discard remaining beats.

Verification
REQ-029 SHALL verify: unsigned 4'b1011, in_b = 0x3F800000 -> 4 beats a_bit 1,1,0,1, a_exp 0,1,2,3, a_sign 0, out_last only on beat 4, b = 0x3F800000, b_zero = 0.
REQ-030 SHALL verify: signed 4'b1000, in_b = 0xC0000000 -> beats a_bit 0,0,0,1, a_sign = 1 only on beat 4 (a_exp 3), b = 0xC0000000.
REQ-031 SHALL verify: two operands with in_valid held and out_ready = 1 -> 8 consecutive out_valid beats, in_ready = 1 only on beat 4, no idle cycle between.
REQ-032 SHALL verify: out_ready = 0 for 3 cycles at beat 2 -> a_bit, a_exp, b, out_last unchanged for those 3 cycles, beat 3 follows after release.
REQ-033 SHALL verify: in_b = 0x00000000, 0x80000000, 0x00400000 -> b_zero = 1; in_b = 0x00800000 -> b_zero = 0.
REQ-034 SHALL verify: reset = 0 asserted during beat 2 -> out_valid = 0 without waiting for a clock edge; after release new operand 4'b0001 yields a_bit 1 at a_exp 0 on the first beat.

Source files
------------

// File: rtl/fxp_bit_serializer.sv
// rtl/fxp_bit_serializer.sv - streams a fixed-point operand LSB-first as weighted bit beats alongside a registered float operand
module fxp_bit_serializer #(
    parameter int FXP_WIDTH     = 4,
    parameter int FP_WIDTH      = 32,
    parameter int FP_FRAC_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FXP_WIDTH-1:0] in_fxp,
    input  logic                 in_signed,
    input  logic [FP_WIDTH-1:0]  in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 a_bit,
    output logic                 a_sign,
    output logic [3:0]           a_exp,
    output logic [FP_WIDTH-1:0]  b,
    output logic                 b_zero,
    output logic                 out_last
);

    localparam int EXP_W = FP_WIDTH - FP_FRAC_WIDTH - 1;
    localparam int IDX_W = (FXP_WIDTH > 2) ? $clog2(FXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FXP_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FXP_WIDTH-1:0]  fxp_q, fxp_d;
    logic                  signed_q, signed_d;
    logic [FP_WIDTH-1:0]   b_q, b_d;
    logic                  b_zero_q, b_zero_d;
    logic                  busy;
    logic                  is_last;
    logic                  accept;

    assign busy      = (state_q == BUSY);
    assign is_last   = busy && (idx_q == LAST_IDX);
    // Accepting on the last handshake lets a new operand follow with no bubble.
    assign in_ready  = !busy || (is_last && out_ready);
    assign accept    = in_valid && in_ready;

    assign out_valid = busy;
    assign out_last  = is_last;
    assign a_bit     = busy && fxp_q[idx_q];
    assign a_sign    = is_last && signed_q;
    assign a_exp     = busy ? 4'(idx_q) : 4'd0;
    assign b         = b_q;
    assign b_zero    = b_zero_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fxp_d    = fxp_q;
        signed_d = signed_q;
        b_d      = b_q;
        b_zero_d = b_zero_q;

        if (busy && out_ready) begin
            if (is_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (accept) begin
            state_d  = BUSY;
            idx_d    = '0;
            fxp_d    = in_fxp;
            signed_d = in_signed;
            b_d      = in_b;
            // Denormals have a zero exponent and are flushed to zero downstream.
            b_zero_d = (in_b[FP_WIDTH-2 -: EXP_W] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            fxp_q    <= '0;
            signed_q <= 1'b0;
            b_q      <= '0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fxp_q    <= fxp_d;
            signed_q <= signed_d;
            b_q      <= b_d;
            b_zero_q <= b_zero_d;
        end
    end

endmodule
